// File: rtl/prio_enc_stream.sv
// Streaming priority encoder: latches an N-bit request vector, then emits one beat per set bit.
// Define PRIO_ENC_LSB_FIRST_EN for ascending (LSB-first) order; default is MSB-first.
module prio_enc_stream #(
    parameter int unsigned N = 12,
    parameter int unsigned W = $clog2(N + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [N-1:0] req,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] first,
    output logic [W-1:0] second,
    output logic [W-1:0] count,
    output logic         out_last
);

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    state_t         state_q;
    logic [N-1:0]   pending_q;
    logic [N-1:0]   pending_d;
    logic [N-1:0]   top_oh;
    logic [W-1:0]   first_c;
    logic [W-1:0]   second_c;
    logic [W-1:0]   count_c;
    logic           last_c;
    logic           busy;

    // Walk from lowest to highest priority so the final hit is first and the one before it is second.
    always_comb begin
        first_c  = '0;
        second_c = '0;
        count_c  = '0;
        top_oh   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            int unsigned idx;
`ifdef PRIO_ENC_LSB_FIRST_EN
            idx = N - k;
`else
            idx = k + 1;
`endif
            if (pending_q[idx-1]) begin
                second_c       = first_c;
                first_c        = W'(idx);
                top_oh         = '0;
                top_oh[idx-1]  = 1'b1;
            end
            count_c = count_c + W'(pending_q[k]);
        end
        last_c    = (count_c <= W'(1));
        pending_d = pending_q & ~top_oh;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pending_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        pending_q <= req;
                        state_q   <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (out_ready) begin
                        pending_q <= pending_d;
                        if (last_c) state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy      = (state_q == S_BUSY);
    assign req_ready = (state_q == S_IDLE);
    assign out_valid = busy;
    assign first     = busy ? first_c  : '0;
    assign second    = busy ? second_c : '0;
    assign count     = busy ? count_c  : '0;
    assign out_last  = busy & last_c;

endmodule
